// File: rtl/wb_port_if.sv
// wb_port_if: write-back request/response bundle between the ALU/memory paths and the register file port
//   alu_*  : ALU result request (valid/ready handshake, dir = destination register, data)
//   mem_*  : memory-load return request (same handshake)
//   *_wb   : registered register-file write strobe, address, data and source select
interface wb_port_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_dir;
    logic [DATA_W-1:0] alu_data;
    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_dir;
    logic [DATA_W-1:0] mem_data;
    logic              reg_wr;
    logic [ADDR_W-1:0] dir_wb;
    logic [DATA_W-1:0] data_wb;
    logic              sel_wb;
    modport master (
        output alu_valid, alu_dir, alu_data, mem_valid, mem_dir, mem_data,
        input  alu_ready, mem_ready, reg_wr, dir_wb, data_wb, sel_wb
    );
    modport slave (
        input  alu_valid, alu_dir, alu_data, mem_valid, mem_dir, mem_data,
        output alu_ready, mem_ready, reg_wr, dir_wb, data_wb, sel_wb
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between the ALU and memory-load paths with anti-starvation
//   clk, rst  : core clock, synchronous active-high reset
//   wb        : wb_port_if slave (requests in, combinational ready out, registered write port out)
//   stall_cnt : saturating count of cycles with a valid-but-not-ready requester (only with WB_STALL_CNT_EN)
module wb_port_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst,
    wb_port_if.slave    wb
`ifdef WB_STALL_CNT_EN
    ,
    output logic [15:0] stall_cnt
`endif
);
    typedef enum logic {ALU_PRI, MEM_PRI} state_t;
    state_t            state;
    logic [3:0]        starve;
    logic [3:0]        starve_inc;
    logic              alu_gnt;
    logic              mem_gnt;
    logic [ADDR_W-1:0] dir_nxt;
    logic [DATA_W-1:0] data_nxt;
    assign wb.alu_ready = state == ALU_PRI || !wb.mem_valid;
    assign wb.mem_ready = state == MEM_PRI || !wb.alu_valid;
    assign alu_gnt      = wb.alu_valid && wb.alu_ready;
    assign mem_gnt      = wb.mem_valid && wb.mem_ready;
    assign starve_inc   = starve + 4'd1;
    always_comb begin
        dir_nxt  = mem_gnt ? wb.mem_dir  : alu_gnt ? wb.alu_dir  : '0;
        data_nxt = mem_gnt ? wb.mem_data : alu_gnt ? wb.alu_data : '0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ALU_PRI;
            starve     <= '0;
            wb.reg_wr  <= 1'b0;
            wb.dir_wb  <= '0;
            wb.data_wb <= '0;
            wb.sel_wb  <= 1'b0;
        end else begin
            wb.reg_wr  <= alu_gnt || mem_gnt;
            wb.dir_wb  <= dir_nxt;
            wb.data_wb <= data_nxt;
            wb.sel_wb  <= mem_gnt;
            // MEM_PRI lasts one cycle: memory is either granted or has dropped valid
            if (state == MEM_PRI) begin
                state  <= ALU_PRI;
                starve <= '0;
            end else if (mem_gnt) begin
                starve <= '0;
            end else if (wb.mem_valid) begin
                starve <= starve_inc;
                if (starve_inc == 4'(STARVE_LIMIT))
                    state <= MEM_PRI;
            end
        end
    end
`ifdef WB_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (((wb.alu_valid && !wb.alu_ready) || (wb.mem_valid && !wb.mem_ready)) && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed vector table plus hand sequences for starvation, reset and stall counter
module tb_wb_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;
    wb_port_if #(.DATA_W(32), .ADDR_W(4)) wb ();
`ifdef WB_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif
    wb_port_arbiter #(.DATA_W(32), .ADDR_W(4), .STARVE_LIMIT(3)) dut (
        .clk(clk),
        .rst(rst),
        .wb(wb)
`ifdef WB_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );
    always #5 clk = ~clk;
    logic [31:0] rf [16];
    initial for (int i = 0; i < 16; i++) rf[i] = 32'h0;
    always @(posedge clk) if (wb.reg_wr) rf[wb.dir_wb] <= wb.data_wb;
    typedef struct {
        logic        av;
        logic [3:0]  ad;
        logic [31:0] adata;
        logic        mv;
        logic [3:0]  md;
        logic [31:0] mdata;
        logic        ear;
        logic        emr;
        logic        ewr;
        logic [3:0]  edir;
        logic [31:0] edata;
        logic        esel;
    } vec_t;
    vec_t v [22];
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask
    task automatic drive(input logic av, input logic [3:0] ad, input logic [31:0] adata,
                         input logic mv, input logic [3:0] md, input logic [31:0] mdata);
        wb.alu_valid = av;
        wb.alu_dir   = ad;
        wb.alu_data  = adata;
        wb.mem_valid = mv;
        wb.mem_dir   = md;
        wb.mem_data  = mdata;
    endtask
    initial begin
        int denials;
        v[0]  = '{1'b0, 4'h0, 32'h0,  1'b0, 4'h0, 32'h0,        1'b1, 1'b1, 1'b0, 4'h0, 32'h0,        1'b0};
        v[1]  = '{1'b1, 4'h3, 32'hAA, 1'b0, 4'h0, 32'h0,        1'b1, 1'b0, 1'b0, 4'h0, 32'h0,        1'b0};
        v[2]  = '{1'b0, 4'h0, 32'h0,  1'b1, 4'h5, 32'hDEADBEEF, 1'b1, 1'b1, 1'b1, 4'h3, 32'hAA,       1'b0};
        v[3]  = '{1'b0, 4'h0, 32'h0,  1'b0, 4'h0, 32'h0,        1'b1, 1'b1, 1'b1, 4'h5, 32'hDEADBEEF, 1'b1};
        v[4]  = '{1'b1, 4'h7, 32'h1,  1'b1, 4'h7, 32'h2,        1'b1, 1'b0, 1'b0, 4'h0, 32'h0,        1'b0};
        v[5]  = '{1'b1, 4'h7, 32'h1,  1'b1, 4'h7, 32'h2,        1'b1, 1'b0, 1'b1, 4'h7, 32'h1,        1'b0};
        v[6]  = '{1'b1, 4'h7, 32'h1,  1'b1, 4'h7, 32'h2,        1'b1, 1'b0, 1'b1, 4'h7, 32'h1,        1'b0};
        v[7]  = '{1'b1, 4'h7, 32'h1,  1'b1, 4'h7, 32'h2,        1'b0, 1'b1, 1'b1, 4'h7, 32'h1,        1'b0};
        v[8]  = '{1'b0, 4'h0, 32'h0,  1'b0, 4'h0, 32'h0,        1'b1, 1'b1, 1'b1, 4'h7, 32'h2,        1'b1};
        v[9]  = '{1'b0, 4'h0, 32'h0,  1'b0, 4'h0, 32'h0,        1'b1, 1'b1, 1'b0, 4'h0, 32'h0,        1'b0};
        v[10] = '{1'b0, 4'h0, 32'h0,  1'b1, 4'h9, 32'h1234,     1'b1, 1'b1, 1'b0, 4'h0, 32'h0,        1'b0};
        v[11] = '{1'b0, 4'h0, 32'h0,  1'b0, 4'h0, 32'h0,        1'b1, 1'b1, 1'b1, 4'h9, 32'h1234,     1'b1};
        v[12] = '{1'b1, 4'h1, 32'h11, 1'b1, 4'h2, 32'h22,       1'b1, 1'b0, 1'b0, 4'h0, 32'h0,        1'b0};
        v[13] = '{1'b1, 4'h1, 32'h11, 1'b1, 4'h2, 32'h22,       1'b1, 1'b0, 1'b1, 4'h1, 32'h11,       1'b0};
        v[14] = '{1'b1, 4'h1, 32'h11, 1'b1, 4'h2, 32'h22,       1'b1, 1'b0, 1'b1, 4'h1, 32'h11,       1'b0};
        v[15] = '{1'b1, 4'h1, 32'h11, 1'b0, 4'h0, 32'h0,        1'b1, 1'b1, 1'b1, 4'h1, 32'h11,       1'b0};
        v[16] = '{1'b1, 4'h1, 32'h11, 1'b1, 4'h2, 32'h22,       1'b1, 1'b0, 1'b1, 4'h1, 32'h11,       1'b0};
        v[17] = '{1'b1, 4'h1, 32'h11, 1'b1, 4'h2, 32'h22,       1'b1, 1'b0, 1'b1, 4'h1, 32'h11,       1'b0};
        v[18] = '{1'b1, 4'h1, 32'h11, 1'b1, 4'h2, 32'h22,       1'b1, 1'b0, 1'b1, 4'h1, 32'h11,       1'b0};
        v[19] = '{1'b1, 4'h1, 32'h11, 1'b1, 4'h2, 32'h22,       1'b0, 1'b1, 1'b1, 4'h1, 32'h11,       1'b0};
        v[20] = '{1'b0, 4'h0, 32'h0,  1'b0, 4'h0, 32'h0,        1'b1, 1'b1, 1'b1, 4'h2, 32'h22,       1'b1};
        v[21] = '{1'b0, 4'h0, 32'h0,  1'b0, 4'h0, 32'h0,        1'b1, 1'b1, 1'b0, 4'h0, 32'h0,        1'b0};
        drive(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_out", {wb.reg_wr, wb.sel_wb, wb.dir_wb, wb.data_wb}, 64'h0);
        chk("reset_fsm", {28'h0, dut.starve, int'(dut.state)}, 64'h0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 22; i++) begin
            drive(v[i].av, v[i].ad, v[i].adata, v[i].mv, v[i].md, v[i].mdata);
            @(negedge clk);
            chk($sformatf("vec%0d_ready", i), {wb.alu_ready, wb.mem_ready}, {v[i].ear, v[i].emr});
            chk($sformatf("vec%0d_out", i), {wb.reg_wr, wb.sel_wb, wb.dir_wb, wb.data_wb},
                {v[i].ewr, v[i].esel, v[i].edir, v[i].edata});
            @(posedge clk);
            #1;
        end
        chk("same_addr_final", rf[7], 32'h2);
        chk("rf_mem_only", rf[5], 32'hDEADBEEF);
        // bounded starvation wait: memory must see exactly STARVE_LIMIT denials
        drive(1'b1, 4'hA, 32'hA0, 1'b1, 4'h6, 32'h66);
        denials = 0;
        forever begin
            @(negedge clk);
            if (wb.mem_ready || denials > 20) break;
            denials++;
            @(posedge clk);
            #1;
        end
        chk("starve_denials", denials, 3);
        chk("starve_mempri", {wb.alu_ready, wb.mem_ready, 31'h0, int'(dut.state)}, {1'b0, 1'b1, 31'h0, 32'd1});
        @(posedge clk);
        #1 drive(1'b1, 4'hA, 32'hA0, 1'b0, 4'h0, 32'h0);
        @(negedge clk);
        chk("starve_mem_write", {wb.reg_wr, wb.sel_wb, wb.dir_wb, wb.data_wb}, {1'b1, 1'b1, 4'h6, 32'h66});
        chk("starve_alu_back", {wb.alu_ready, 31'h0, int'(dut.state)}, {1'b1, 63'h0});
        // reset asserted in the cycle memory is granted from MEM_PRI
        @(posedge clk);
        #1 drive(1'b1, 4'h8, 32'h88, 1'b1, 4'hC, 32'hBAD);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mid_mempri", {wb.alu_ready, wb.mem_ready}, 2'b01);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        drive(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0);
        @(negedge clk);
        chk("rst_mid_out", {wb.reg_wr, wb.sel_wb, wb.dir_wb, wb.data_wb}, 64'h0);
        chk("rst_mid_fsm", {28'h0, dut.starve, int'(dut.state)}, 64'h0);
        @(posedge clk);
        #1;
        chk("rst_mid_nowrite", rf[12], 32'h0);
`ifdef WB_STALL_CNT_EN
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("stall_reset", stall_cnt, 64'h0);
        @(posedge clk);
        #1 drive(1'b1, 4'h1, 32'h1, 1'b1, 4'h2, 32'h2);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("stall_starve", stall_cnt, 64'd3);
        chk("stall_grant_cycle", wb.mem_ready, 1'b1);
        repeat (70000) @(posedge clk);
        @(negedge clk);
        chk("stall_saturate", stall_cnt, 64'hFFFF);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
